regfile: RTL and testbench

Integer register file for the single-cycle RV32I core, at the opposite end of the datapath from the ALU. It supplies the two source operands the ALU consumes (rs1 → ALU A, rs2 → ALU B or immediate mux) and captures the ALU/write-back result into the destination register on the clock edge. It provides 32 × 32-bit architectural registers with x0 hardwired to zero, two asynchronous read ports and one synchronous write port. An optional same-cycle write-to-read bypass is compile-time selectable.

---
 rtl/regfile_if.sv | 24 ++
 rtl/regfile.sv | 57 +++++
 tb/tb_regfile.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/regfile_if.sv
// Register-file access bundle: two combinational read ports and one write-back port.
// The core drives addresses and write-back through the master modport; the register file uses the slave modport.
interface regfile_if #(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned ADDR_W = 5
);
   logic [ADDR_W-1:0] i_rs1Addr;
   logic [DATA_W-1:0] o_rs1Data;
   logic [ADDR_W-1:0] i_rs2Addr;
   logic [DATA_W-1:0] o_rs2Data;
   logic              i_rdWrEn;
   logic [ADDR_W-1:0] i_rdAddr;
   logic [DATA_W-1:0] i_rdData;

   modport master (
      output i_rs1Addr, i_rs2Addr, i_rdWrEn, i_rdAddr, i_rdData,
      input  o_rs1Data, o_rs2Data
   );

   modport slave (
      input  i_rs1Addr, i_rs2Addr, i_rdWrEn, i_rdAddr, i_rdData,
      output o_rs1Data, o_rs2Data
   );
endinterface

// File: rtl/regfile.sv
// RV32I integer register file: x0 hardwired to zero, two async read ports, one sync write port.
// Optional write-first bypass from the write port to the read ports: define REGFILE_BYPASS_EN.
module regfile #(
   parameter int unsigned DATA_W   = 32,
   parameter int unsigned NUM_REGS = 32
) (
   input logic       i_clk,
   input logic       i_rst,
   regfile_if.slave  rf
);
   localparam int unsigned ADDR_W = $clog2(NUM_REGS);

   // x0 is not stored; entries 1..NUM_REGS-1 only
   logic [DATA_W-1:0] r_regs [NUM_REGS-1:1];

   logic [DATA_W-1:0] w_rs1Stored;
   logic [DATA_W-1:0] w_rs2Stored;

   // Reset clears every register and overrides a simultaneous write
   always_ff @(posedge i_clk) begin
      for (int i = 1; i < int'(NUM_REGS); i++) begin
         if (i_rst) begin
            r_regs[i] <= '0;
         end else if (rf.i_rdWrEn && (rf.i_rdAddr == ADDR_W'(i))) begin
            r_regs[i] <= rf.i_rdData;
         end
      end
   end

   // Read muxes; address 0 falls through to the zero default
   always_comb begin
      w_rs1Stored = '0;
      w_rs2Stored = '0;
      for (int i = 1; i < int'(NUM_REGS); i++) begin
         if (rf.i_rs1Addr == ADDR_W'(i)) w_rs1Stored = r_regs[i];
         if (rf.i_rs2Addr == ADDR_W'(i)) w_rs2Stored = r_regs[i];
      end
   end

`ifdef REGFILE_BYPASS_EN
   logic w_wrLive;
   logic w_rs1Fwd;
   logic w_rs2Fwd;

   // Forward the in-flight write-back value; never for x0 or during reset
   assign w_wrLive = rf.i_rdWrEn && !i_rst && (rf.i_rdAddr != '0);
   assign w_rs1Fwd = w_wrLive && (rf.i_rs1Addr == rf.i_rdAddr);
   assign w_rs2Fwd = w_wrLive && (rf.i_rs2Addr == rf.i_rdAddr);

   assign rf.o_rs1Data = w_rs1Fwd ? rf.i_rdData : w_rs1Stored;
   assign rf.o_rs2Data = w_rs2Fwd ? rf.i_rdData : w_rs2Stored;
`else
   assign rf.o_rs1Data = w_rs1Stored;
   assign rf.o_rs2Data = w_rs2Stored;
`endif

endmodule

// File: tb/tb_regfile.sv
// Scoreboard bench for regfile: driver pushes expected read values from an array model, monitor pops and compares.
module tb_regfile;
   logic clk;
   logic rst;

   regfile_if #(.DATA_W(32), .ADDR_W(5)) bus ();

   regfile #(.DATA_W(32), .NUM_REGS(32)) dut (
      .i_clk (clk),
      .i_rst (rst),
      .rf    (bus.slave)
   );

   typedef struct packed {
      logic [4:0]  a1;
      logic [4:0]  a2;
      logic [31:0] e1;
      logic [31:0] e2;
   } exp_t;

   exp_t        sb[$];
   logic [31:0] mdl [32];
   logic        chk_vld;
   int          n_checks;
   int          n_fail;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Architectural view of a read given the write being presented this cycle
   function automatic logic [31:0] model_read(input logic [4:0] a, input logic r,
                                              input logic we, input logic [4:0] rd,
                                              input logic [31:0] d);
      if (a == 5'd0) return 32'h0;
`ifdef REGFILE_BYPASS_EN
      if (!r && we && rd == a) return d;
`endif
      return mdl[a];
   endfunction

   task automatic cycle(input logic r, input logic we, input logic [4:0] rd,
                        input logic [31:0] d, input logic [4:0] a1, input logic [4:0] a2);
      exp_t e;
      @(posedge clk);
      #1;
      rst           = r;
      bus.i_rdWrEn  = we;
      bus.i_rdAddr  = rd;
      bus.i_rdData  = d;
      bus.i_rs1Addr = a1;
      bus.i_rs2Addr = a2;
      e.a1 = a1;
      e.a2 = a2;
      e.e1 = model_read(a1, r, we, rd, d);
      e.e2 = model_read(a2, r, we, rd, d);
      sb.push_back(e);
      chk_vld = 1'b1;
      if (r) begin
         for (int i = 0; i < 32; i++) mdl[i] = 32'h0;
      end else if (we && rd != 5'd0) begin
         mdl[rd] = d;
      end
   endtask

   // Monitor: read outputs are valid mid-cycle, once the driver has presented inputs
   always @(negedge clk) begin
      exp_t e;
      if (chk_vld) begin
         n_checks++;
         if (sb.size() == 0) begin
            n_fail++;
            $display("FAIL sb_underflow: actual=empty required=entry t=%0t", $time);
         end else begin
            e = sb.pop_front();
            n_checks++;
            if (bus.o_rs1Data !== e.e1) begin
               n_fail++;
               $display("FAIL rs1_read x%0d: actual=%08h required=%08h t=%0t",
                        e.a1, bus.o_rs1Data, e.e1, $time);
            end
            if (bus.o_rs2Data !== e.e2) begin
               n_fail++;
               $display("FAIL rs2_read x%0d: actual=%08h required=%08h t=%0t",
                        e.a2, bus.o_rs2Data, e.e2, $time);
            end
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      n_checks = 0;
      n_fail   = 0;
      chk_vld  = 1'b0;
      rst      = 1'b0;
      bus.i_rdWrEn  = 1'b0;
      bus.i_rdAddr  = '0;
      bus.i_rdData  = '0;
      bus.i_rs1Addr = '0;
      bus.i_rs2Addr = '0;
      for (int i = 0; i < 32; i++) mdl[i] = 32'h0;

      // Initial reset, reading x0 only while contents are unknown
      cycle(1'b1, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0);

      // Reset clear after a write, then sweep all addresses
      cycle(1'b0, 1'b1, 5'd5, 32'hDEAD_BEEF, 5'd5, 5'd0);
      cycle(1'b1, 1'b0, 5'd0, 32'h0, 5'd5, 5'd5);
      for (int i = 0; i < 16; i++)
         cycle(1'b0, 1'b0, 5'd0, 32'h0, 5'(2 * i), 5'(2 * i + 1));

      // Basic write/read
      cycle(1'b0, 1'b1, 5'd1, 32'h0000_0007, 5'd0, 5'd0);
      cycle(1'b0, 1'b1, 5'd2, 32'hFFFF_FFF9, 5'd1, 5'd0);
      cycle(1'b0, 1'b0, 5'd0, 32'h0, 5'd1, 5'd2);

      // x0 immunity
      cycle(1'b0, 1'b1, 5'd0, 32'h1234_5678, 5'd0, 5'd0);
      cycle(1'b0, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0);

      // Write-enable gating
      cycle(1'b0, 1'b1, 5'd3, 32'h0000_0011, 5'd3, 5'd0);
      cycle(1'b0, 1'b0, 5'd3, 32'hAAAA_AAAA, 5'd3, 5'd3);
      cycle(1'b0, 1'b0, 5'd0, 32'h0, 5'd3, 5'd3);

      // Same-cycle read of the register being written
      cycle(1'b0, 1'b1, 5'd4, 32'h0000_0001, 5'd0, 5'd0);
      cycle(1'b0, 1'b1, 5'd4, 32'h0000_0002, 5'd4, 5'd4);
      cycle(1'b0, 1'b0, 5'd0, 32'h0, 5'd4, 5'd0);

      // Reset vs write collision, then a normal write to the same register
      cycle(1'b0, 1'b1, 5'd6, 32'h0BAD_F00D, 5'd0, 5'd0);
      cycle(1'b1, 1'b1, 5'd6, 32'h5555_5555, 5'd6, 5'd0);
      cycle(1'b0, 1'b1, 5'd6, 32'h0000_0066, 5'd6, 5'd6);
      cycle(1'b0, 1'b0, 5'd0, 32'h0, 5'd6, 5'd6);

      // Random traffic with occasional reset
      for (int n = 0; n < 3000; n++) begin
         logic        r;
         logic        we;
         logic [4:0]  rd;
         logic [4:0]  a1;
         logic [4:0]  a2;
         logic [31:0] d;
         r  = ($urandom_range(0, 99) == 0);
         we = ($urandom_range(0, 3) != 0);
         rd = 5'($urandom_range(0, 31));
         d  = $urandom;
         a1 = ($urandom_range(0, 3) == 0) ? rd : 5'($urandom_range(0, 31));
         a2 = ($urandom_range(0, 3) == 0) ? rd : 5'($urandom_range(0, 31));
         cycle(r, we, rd, d, a1, a2);
      end

      // Drain: last entry is popped at this negedge
      @(negedge clk);
      #1;
      chk_vld = 1'b0;
      n_checks++;
      if (sb.size() != 0) begin
         n_fail++;
         $display("FAIL sb_drain: actual=%0d required=0", sb.size());
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
